// File: rtl/conv1d_pkg.sv
// Shared constants and state type for the conv1d input feeder.
// The ring geometry and the CFU command codes live here.
package conv1d_pkg;

    localparam int unsigned KERNEL_LENGTH      = 8;
    localparam int unsigned PAD_PRE            = 4;
    localparam int unsigned PAD_POST           = KERNEL_LENGTH - 1 - PAD_PRE;
    localparam int unsigned MAX_INPUT_CHANNELS = 128;
    localparam int unsigned MAX_INPUT_SIZE     = 1024;

    localparam logic [6:0] CMD_WRITE_INPUT = 7'd1;
    localparam logic [6:0] CMD_START_X     = 7'd8;

    typedef enum logic [2:0] {
        StIdle,
        StPadPre,
        StData,
        StPadPost,
        StDrain
    } feeder_state_t;

endpackage

// File: rtl/conv1d_input_feeder_if.sv
// Handshake and bus bundle between the activation source, the feeder and the conv1d buffer.
// The feeder uses the slave view; whoever drives the stream and consumes windows uses master.
interface conv1d_input_feeder_if;

    logic        start;
    logic [31:0] cfg_depth;
    logic [31:0] cfg_width;
    logic [7:0]  cfg_pad_value;
    logic        in_valid;
    logic [31:0] in_data;
    logic        in_ready;
    logic        wr_valid;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic        window_valid;
    logic [2:0]  window_slot;
    logic        window_release;
    logic        busy;
    logic        done;
    logic        cfg_err;

    modport slave (
        input  start, cfg_depth, cfg_width, cfg_pad_value, in_valid, in_data, window_release,
        output in_ready, wr_valid, wr_addr, wr_data, window_valid, window_slot, busy, done,
        cfg_err
    );

    modport master (
        output start, cfg_depth, cfg_width, cfg_pad_value, in_valid, in_data, window_release,
        input  in_ready, wr_valid, wr_addr, wr_data, window_valid, window_slot, busy, done,
        cfg_err
    );

endinterface

// File: rtl/conv1d_ring_addr_gen.sv
// Slot/word counters for the 8-slot input ring and the byte address of the current word.
// One step advances a word; the slot wraps 7->0 after the last word of a column.
module conv1d_ring_addr_gen (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_clear,
    input  logic       i_step,
    input  logic [7:0] i_depth,
    output logic [2:0] o_slot,
    output logic       o_last,
    output logic [9:0] o_addr
);

    logic [2:0] r_slot;
    logic [4:0] r_word;
    logic [5:0] w_last_idx;
    logic [9:0] w_base;

    assign w_last_idx = i_depth[7:2] - 6'd1;
    // slot*depth never exceeds 7*128, so a 10-bit product is exact
    assign w_base     = 10'(r_slot) * {2'b00, i_depth};
    assign o_addr     = w_base + {3'b000, r_word, 2'b00};
    assign o_last     = ({1'b0, r_word} == w_last_idx);
    assign o_slot     = r_slot;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_slot <= 3'd0;
            r_word <= 5'd0;
        end else if (i_clear) begin
            r_slot <= 3'd0;
            r_word <= 5'd0;
        end else if (i_step) begin
            if (o_last) begin
                r_word <= 5'd0;
                r_slot <= r_slot + 3'd1;
            end else begin
                r_word <= r_word + 5'd1;
            end
        end
    end

endmodule

// File: rtl/conv1d_input_feeder.sv
// Turns a packed int8 activation stream into padded column writes of the conv1d input ring
// and publishes the oldest resident slot of each complete 8-column window.
module conv1d_input_feeder
    import conv1d_pkg::*;
(
    input logic                  i_clk,
    input logic                  i_reset,
    conv1d_input_feeder_if.slave io_bus
);

    localparam logic [10:0] PadPreEnd  = 11'(PAD_PRE - 1);
    localparam logic [10:0] PadPostEnd = 11'(PAD_PRE + PAD_POST - 1);

    feeder_state_t r_state, w_state_d;

    logic [7:0]  r_depth;
    logic [7:0]  r_pad;
    logic [10:0] r_width;
    logic [10:0] r_col_cnt;
    logic [10:0] r_win_cnt;
    logic [3:0]  r_resident;
    logic        r_wr_valid;
    logic [9:0]  r_wr_addr;
    logic [31:0] r_wr_data;
    logic        r_done;
    logic        r_cfg_err;

    logic        w_cfg_ok;
    logic        w_start_go;
    logic        w_busy;
    logic        w_full;
    logic        w_win_valid;
    logic        w_release;
    logic        w_free;
    logic        w_pad_phase;
    logic        w_issue;
    logic        w_last_word;
    logic        w_col_done;
    logic        w_last_rel;
    logic [2:0]  w_slot;
    logic [9:0]  w_addr;
    logic [10:0] w_data_end;
    logic [10:0] w_post_end;
    logic [31:0] w_wr_data;

    assign w_cfg_ok = (io_bus.cfg_depth >= 32'd4) && (io_bus.cfg_depth <= MAX_INPUT_CHANNELS) &&
                      (io_bus.cfg_depth[1:0] == 2'b00) && (io_bus.cfg_width >= 32'd1) &&
                      (io_bus.cfg_width <= MAX_INPUT_SIZE);
    assign w_start_go = (r_state == StIdle) && io_bus.start && w_cfg_ok;

    assign w_busy      = (r_state != StIdle);
    assign w_full      = (r_resident == 4'd8);
    assign w_win_valid = w_full && w_busy;
    assign w_release   = w_win_valid && io_bus.window_release;
    // a release frees the oldest slot in time for a same-cycle write into it
    assign w_free      = !w_full || w_release;
    assign w_pad_phase = (r_state == StPadPre) || (r_state == StPadPost);
    assign w_issue     = w_free && (w_pad_phase || ((r_state == StData) && io_bus.in_valid));
    assign w_col_done  = w_issue && w_last_word;
    assign w_last_rel  = w_release && (r_win_cnt == 11'd1);
    assign w_wr_data   = w_pad_phase ? {4{r_pad}} : io_bus.in_data;
    assign w_data_end  = r_width + PadPreEnd;
    assign w_post_end  = r_width + PadPostEnd;

    conv1d_ring_addr_gen u_addr_gen (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_clear (w_start_go),
        .i_step  (w_issue),
        .i_depth (r_depth),
        .o_slot  (w_slot),
        .o_last  (w_last_word),
        .o_addr  (w_addr)
    );

    always_comb begin
        w_state_d = r_state;
        unique case (r_state)
            StIdle:    if (w_start_go) w_state_d = StPadPre;
            StPadPre:  if (w_col_done && (r_col_cnt == PadPreEnd)) w_state_d = StData;
            StData:    if (w_col_done && (r_col_cnt == w_data_end)) w_state_d = StPadPost;
            StPadPost: if (w_col_done && (r_col_cnt == w_post_end)) w_state_d = StDrain;
            StDrain:   w_state_d = StDrain;
            default:   w_state_d = StIdle;
        endcase
        if (w_last_rel) w_state_d = StIdle;
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state    <= StIdle;
            r_depth    <= 8'd0;
            r_pad      <= 8'd0;
            r_width    <= 11'd0;
            r_col_cnt  <= 11'd0;
            r_win_cnt  <= 11'd0;
            r_resident <= 4'd0;
            r_wr_valid <= 1'b0;
            r_wr_addr  <= 10'd0;
            r_wr_data  <= 32'd0;
            r_done     <= 1'b0;
            r_cfg_err  <= 1'b0;
        end else begin
            r_state    <= w_state_d;
            r_wr_valid <= w_issue;
            r_done     <= w_last_rel;
            if (w_issue) begin
                r_wr_addr <= w_addr;
                r_wr_data <= w_wr_data;
            end
            if ((r_state == StIdle) && io_bus.start) begin
                r_cfg_err <= !w_cfg_ok;
                if (w_cfg_ok) begin
                    r_depth    <= io_bus.cfg_depth[7:0];
                    r_width    <= io_bus.cfg_width[10:0];
                    r_pad      <= io_bus.cfg_pad_value;
                    r_col_cnt  <= 11'd0;
                    r_win_cnt  <= io_bus.cfg_width[10:0];
                    r_resident <= 4'd0;
                end
            end else begin
                r_resident <= r_resident + 4'(w_col_done) - 4'(w_release);
                if (w_col_done) r_col_cnt <= r_col_cnt + 11'd1;
                if (w_release)  r_win_cnt <= r_win_cnt - 11'd1;
            end
        end
    end

    assign io_bus.in_ready     = (r_state == StData) && w_free;
    assign io_bus.wr_valid     = r_wr_valid;
    assign io_bus.wr_addr      = {22'd0, r_wr_addr};
    assign io_bus.wr_data      = r_wr_data;
    assign io_bus.window_valid = w_win_valid;
    // with 8 resident the oldest slot equals the next write slot
    assign io_bus.window_slot  = w_win_valid ? (w_slot - r_resident[2:0]) : 3'd0;
    assign io_bus.busy         = w_busy;
    assign io_bus.done         = r_done;
    assign io_bus.cfg_err      = r_cfg_err;

endmodule

// File: tb/tb_conv1d_input_feeder.sv
// Randomized bench for conv1d_input_feeder: a column/window model derived from column indices
// and release counts predicts every write beat, window and handshake cycle by cycle.
module tb_conv1d_input_feeder;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    conv1d_input_feeder_if bus ();

    conv1d_input_feeder dut (
        .i_clk   (clk),
        .i_reset (rst),
        .io_bus  (bus.slave)
    );

    int n_vec = 0;
    int n_err = 0;

    int          m_depth, m_n, m_w, m_beats, m_rel;
    logic [7:0]  m_pad;
    bit          m_busy;
    logic [31:0] acc_q[$];
    logic [31:0] addr_log[$];
    logic [31:0] data_log[$];
    logic [31:0] slot_log[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // beat b belongs to column b/N; column c lives in slot c%8
    function automatic logic [31:0] exp_addr(input int beat);
        int col;
        col = beat / m_n;
        return 32'((col % 8) * m_depth + (beat % m_n) * 4);
    endfunction

    function automatic logic [31:0] exp_data(input int beat);
        int col, idx;
        col = beat / m_n;
        if (col < 4 || col >= 4 + m_w) return {4{m_pad}};
        idx = (col - 4) * m_n + beat % m_n;
        if (idx < acc_q.size()) return acc_q[idx];
        return 32'hdeadbeef;
    endfunction

    task automatic run_seq(input int depth, input int w, input logic [7:0] pad, input int pv,
                           input int pr, input int hold, input int rst_beat,
                           input int stall_beat, input bit poke);
        bit          p_issue, p_acc, p_rel, exp_wv, exp_done, room, is_data, exp_ready;
        bit          finished, stalled;
        logic [31:0] p_data, p_slot;
        int          col, stall;
        m_depth = depth; m_n = depth / 4; m_w = w; m_pad = pad;
        m_beats = 0; m_rel = 0; m_busy = 0;
        acc_q.delete(); addr_log.delete(); data_log.delete(); slot_log.delete();
        p_issue = 0; p_acc = 0; p_rel = 0; p_data = 0; p_slot = 0;
        stall = 0; stalled = 0; finished = 0;
        bus.cfg_depth = depth; bus.cfg_width = w; bus.cfg_pad_value = pad;
        bus.start = 1'b1; bus.in_valid = 1'b0; bus.window_release = 1'b0;
        for (int cyc = 0; cyc < 20000 && !finished; cyc++) begin
            @(posedge clk); #1;
            if (cyc == 0) m_busy = 1;
            if (p_acc) acc_q.push_back(p_data);
            exp_done = 0;
            if (p_rel) begin
                slot_log.push_back(p_slot);
                m_rel++;
                if (m_rel == m_w) begin
                    m_busy = 0;
                    exp_done = 1;
                end
            end
            chk("wr_valid", bus.wr_valid, p_issue);
            if (bus.wr_valid) begin
                addr_log.push_back(bus.wr_addr);
                data_log.push_back(bus.wr_data);
                chk("wr_addr", bus.wr_addr, exp_addr(m_beats));
                chk("wr_data", bus.wr_data, exp_data(m_beats));
                m_beats++;
            end
            exp_wv = m_busy && (m_beats / m_n >= m_rel + 8);
            chk("window_valid", bus.window_valid, exp_wv);
            if (exp_wv) chk("window_slot", bus.window_slot, m_rel % 8);
            chk("busy", bus.busy, m_busy);
            chk("done", bus.done, exp_done);
            chk("cfg_err", bus.cfg_err, 0);
            if (hold > 100 && cyc == hold - 1) chk("full_ring_beats", addr_log.size(), 8 * m_n);
            if (rst_beat >= 0 && m_beats >= rst_beat) begin
                rst = 1'b1;
                bus.in_valid = 1'b0; bus.window_release = 1'b0; bus.start = 1'b0;
                #1;
                chk("rst_wr_valid", bus.wr_valid, 0);
                chk("rst_window_valid", bus.window_valid, 0);
                chk("rst_busy", bus.busy, 0);
                chk("rst_in_ready", bus.in_ready, 0);
                @(posedge clk); #1;
                rst = 1'b0;
                return;
            end
            if (!m_busy) begin
                finished = 1;
                bus.in_valid = 1'b0; bus.window_release = 1'b0; bus.start = 1'b0;
            end else begin
                col = m_beats / m_n;
                if (stall_beat >= 0 && m_beats == stall_beat && !stalled) begin
                    stall = 5;
                    stalled = 1;
                end
                bus.in_valid = (stall > 0) ? 1'b0 : ($urandom_range(99) < pv);
                if (stall > 0) stall--;
                bus.in_data = $urandom;
                bus.window_release = (cyc >= hold) && ($urandom_range(99) < pr);
                if (poke && cyc == 6) begin
                    bus.start = 1'b1; bus.cfg_depth = 4; bus.cfg_width = 2;
                end else begin
                    bus.start = 1'b0; bus.cfg_depth = depth; bus.cfg_width = w;
                end
                p_rel = bus.window_release && exp_wv;
                p_slot = 32'(bus.window_slot);
                #1;
                room = (col < m_w + 7) && (col < m_rel + int'(p_rel) + 8);
                is_data = (col >= 4) && (col < 4 + m_w);
                exp_ready = room && is_data;
                chk("in_ready", bus.in_ready, exp_ready);
                p_issue = room && (!is_data || bus.in_valid);
                p_acc = exp_ready && bus.in_valid;
                p_data = bus.in_data;
            end
        end
        if (!finished) begin
            n_vec++; n_err++;
            $display("FAIL timeout: still busy after 20000 cycles, required done");
        end
        @(posedge clk); #1;
        chk("done_pulse_end", bus.done, 0);
        chk("idle_busy", bus.busy, 0);
        chk("idle_wr_valid", bus.wr_valid, 0);
    endtask

    task automatic bad_start(input int depth, input int w);
        bus.cfg_depth = depth; bus.cfg_width = w; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        chk("bad_cfg_err", bus.cfg_err, 1);
        chk("bad_busy", bus.busy, 0);
        repeat (5) begin
            @(posedge clk); #1;
            chk("bad_wr_valid", bus.wr_valid, 0);
            chk("bad_cfg_err_sticky", bus.cfg_err, 1);
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.start = 1'b0; bus.cfg_depth = 0; bus.cfg_width = 0; bus.cfg_pad_value = 0;
        bus.in_valid = 1'b0; bus.in_data = 0; bus.window_release = 1'b0;
        @(posedge clk); #1;
        chk("reset_wr_valid", bus.wr_valid, 0);
        chk("reset_wr_addr", bus.wr_addr, 0);
        chk("reset_wr_data", bus.wr_data, 0);
        chk("reset_window_valid", bus.window_valid, 0);
        chk("reset_window_slot", bus.window_slot, 0);
        chk("reset_busy", bus.busy, 0);
        chk("reset_done", bus.done, 0);
        chk("reset_cfg_err", bus.cfg_err, 0);
        chk("reset_in_ready", bus.in_ready, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // depth 8, W=1: slots 0-3 pad, slot 4 data, slots 5-7 pad
        run_seq(8, 1, 8'h80, 100, 100, 0, -1, -1, 1'b0);
        chk("a_beats", addr_log.size(), 16);
        chk("a_pad0", data_log[0], 32'h80808080);
        chk("a_addr_slot4", addr_log[8], 32);
        chk("a_data_slot4", data_log[8], acc_q[0]);
        chk("a_data_slot4w1", data_log[9], acc_q[1]);
        chk("a_pad_slot5", data_log[10], 32'h80808080);
        chk("a_last_addr", addr_log[15], 60);
        chk("a_win_slot", slot_log[0], 0);

        // depth 4, W=3: windows at slots 0,1,2; columns 8,9 reuse slots 0,1
        run_seq(4, 3, 8'h11, 100, 100, 0, -1, -1, 1'b0);
        chk("b_beats", addr_log.size(), 10);
        chk("b_win0", slot_log[0], 0);
        chk("b_win1", slot_log[1], 1);
        chk("b_win2", slot_log[2], 2);
        chk("b_col8_addr", addr_log[8], 0);
        chk("b_col9_addr", addr_log[9], 4);

        // full ring held for 300 cycles before any release
        run_seq(8, 5, 8'h7f, 80, 50, 300, -1, -1, 1'b0);

        // 5-cycle stall in the middle of the first data column
        run_seq(16, 4, 8'h00, 100, 60, 0, -1, 4 * 4 + 1, 1'b0);
        chk("bp_addr", addr_log[18], 72);

        bad_start(6, 4);
        bad_start(8, 0);
        run_seq(4, 2, 8'h22, 90, 70, 0, -1, -1, 1'b0);

        // async reset mid-data, then a clean restart from slot 0
        run_seq(8, 6, 8'h80, 100, 30, 0, 4 * 2 + 1, -1, 1'b0);
        run_seq(8, 2, 8'h01, 90, 70, 0, -1, -1, 1'b0);
        chk("restart_addr0", addr_log[0], 0);

        run_seq(128, 1, 8'hc3, 100, 100, 0, -1, -1, 1'b0);
        chk("max_addr", addr_log[255], 1020);

        for (int i = 0; i < 8; i++) begin
            run_seq(4 * int'($urandom_range(1, 8)), int'($urandom_range(1, 20)),
                    8'($urandom), int'($urandom_range(40, 100)), int'($urandom_range(20, 100)),
                    0, -1, -1, (i % 2) == 1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
